multi_input_logic_gate_unit: RTL and testbench
==============================================

// Module: multi_input_logic_gate_unit
// PURPOSE
//  Parametrised, pipelined successor to the fixed 3-input NAND gate.
//  Each of CHANNELS channels reduces N_INPUTS bits with a runtime-selected gate function.
//  Two-stage ready/valid pipeline; sits between the switch/stimulus logic and the LED/check logic.
// PARAMETERS
//  N_INPUTS  3   gate inputs per channel (legal: 2..16)
//  CHANNELS  4   independent gate channels (legal: 1..32)
//  CNT_W     16  width of event counter (used only with GATE_EVENT_CNT_EN)
// PORTS
//  clk        in   1                  rising-edge clock
//  rst_n      in   1                  async active-low reset
//  in_valid   in   1                  in_data/in_mode valid this cycle
//  in_ready   out  1                  unit accepts input this cycle
//  in_mode    in   3                  gate function (see BEHAVIOUR)
//  in_data    in   N_INPUTS*CHANNELS  channel c = in_data[c*N_INPUTS +: N_INPUTS]
//  out_valid  out  1                  out_data valid
//  out_ready  in   1                  consumer accepts out_data
//  out_data   out  CHANNELS           bit c = result of channel c
//  out_mode   out  3                  mode that produced out_data
//  evt_count  out  CNT_W              (GATE_EVENT_CNT_EN only) result-one event count
// BEHAVIOUR
//  - Modes: 000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR (odd parity), 101 XNOR,
//    110 BUF (input bit 0 only), 111 NOT (~input bit 0). Reduction over all N_INPUTS bits.
//  - Stage S1 registers in_data+in_mode; stage S2 registers per-channel result+mode.
//  - Transfer rule: a stage loads when its upstream is valid and (stage empty or downstream takes).
//    s2_take = ~s2_valid | out_ready; s1_take = ~s1_valid | s2_take; in_ready = s1_take.
//  - Input accepted on (in_valid & in_ready). Output consumed on (out_valid & out_ready).
//  - Latency: accepted at edge N -> out_valid high after edge N+2 with out_ready held 1.
//  - Throughput: one result/cycle with out_ready=1; no bubbles, no drops, no duplicates.
//  - Stall: out_ready=0 with out_valid=1 -> out_data/out_mode held stable;
//    S1 fills, then in_ready drops combinationally the same cycle both stages are full.
//  - in_ready depends on out_ready combinationally (no skid buffer); out_* are registered only.
//  - in_data/in_mode ignored when in_valid=0 or in_ready=0.
//  - Simultaneous accept+consume at full pipeline: both stages advance in the same edge.
//  - Reset (async assert, any time incl. mid-transfer): s1_valid=0, out_valid=0,
//    out_data=0, out_mode=000, evt_count=0; in-flight data discarded. in_ready=1 while
//    reset is asserted and on the first cycle after release.
//  - No combinational path from in_data to out_data.
// CONFIGURATION
//  - GATE_EVENT_CNT_EN defined: evt_count adds popcount(S2 result) on each
//    consumed output, saturating at 2^CNT_W-1 (never wraps). Clears only on reset.
//  - GATE_EVENT_CNT_EN undefined: evt_count port absent; no counter logic.
// TESTING (N_INPUTS=3, CHANNELS=4 unless stated)
//  1. mode=001, in_data=12'hFFF, out_ready=1 -> 2 cycles later out_data=4'h0, out_mode=001;
//     in_data=12'h000 -> out_data=4'hF.
//  2. Sweep all 8 modes x all 8 patterns on ch0 (others 0) -> bit0 matches truth table, bits1-3 match mode on 000.
//  3. Stream 10 back-to-back inputs; out_ready low for cycles 3-6 -> in_ready low after 2 accepted
//     during stall; all 10 results emerge in order, none lost or repeated.
//  4. rst_n low mid-stream with both stages full -> out_valid=0, out_data=0 immediately (async);
//     after release, first new input emerges after 2 cycles.
//  5. GATE_EVENT_CNT_EN, CNT_W=4, mode=000, in_data=12'hFFF x5 consumed -> evt_count 4,8,12,15,15 (saturates).
//  6. N_INPUTS=5, CHANNELS=1, mode=100, in_data=5'b10110 -> out_data=1; 5'b10010 -> 0.

Source files
------------

// File: rtl/multi_input_logic_gate_unit.sv
// CHANNELS parallel N_INPUTS-bit gate reductions behind a two-stage ready/valid pipeline.
// Define GATE_EVENT_CNT_EN to add the saturating result-one event counter (evt_count).
module multi_input_logic_gate_unit #(
    parameter int N_INPUTS = 3,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   in_mode,
    input  logic [N_INPUTS*CHANNELS-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS-1:0]          out_data,
    output logic [2:0]                   out_mode
`ifdef GATE_EVENT_CNT_EN
    ,
    output logic [CNT_W-1:0]             evt_count
`endif
);

    localparam int DATA_BITS = N_INPUTS * CHANNELS;

    localparam logic [2:0] MODE_AND  = 3'b000;
    localparam logic [2:0] MODE_NAND = 3'b001;
    localparam logic [2:0] MODE_OR   = 3'b010;
    localparam logic [2:0] MODE_NOR  = 3'b011;
    localparam logic [2:0] MODE_XOR  = 3'b100;
    localparam logic [2:0] MODE_XNOR = 3'b101;
    localparam logic [2:0] MODE_BUF  = 3'b110;

    if (N_INPUTS < 2 || N_INPUTS > 16 || CHANNELS < 1 || CHANNELS > 32 || CNT_W < 1) begin : g_param_check
        $error("multi_input_logic_gate_unit: parameter out of legal range");
    end

    function automatic logic gate_reduce(input logic [N_INPUTS-1:0] bits, input logic [2:0] mode);
        logic r;
        case (mode)
            MODE_AND:  r = &bits;
            MODE_NAND: r = ~(&bits);
            MODE_OR:   r = |bits;
            MODE_NOR:  r = ~(|bits);
            MODE_XOR:  r = ^bits;
            MODE_XNOR: r = ~(^bits);
            MODE_BUF:  r = bits[0];
            default:   r = ~bits[0];
        endcase
        return r;
    endfunction

    logic                 vld_p1;
    logic [DATA_BITS-1:0] data_p1;
    logic [2:0]           mode_p1;
    logic [CHANNELS-1:0]  gate_p1;

    logic                 vld_p2;
    logic [CHANNELS-1:0]  res_p2;
    logic [2:0]           mode_p2;

    logic take_p1;
    logic take_p2;
    logic accept;

    // Each stage advances when empty or when the stage below is taking its content.
    assign take_p2  = ~vld_p2 | out_ready;
    assign take_p1  = ~vld_p1 | take_p2;
    assign in_ready = take_p1;
    assign accept   = in_valid & take_p1;

    // ---- stage p1: capture raw input vector and mode ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (take_p1) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            data_p1 <= in_data;
            mode_p1 <= in_mode;
        end
    end

    always_comb begin
        gate_p1 = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            gate_p1[c] = gate_reduce(data_p1[c*N_INPUTS +: N_INPUTS], mode_p1);
        end
    end

    // ---- stage p2: registered per-channel result, visible on the output ports ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            res_p2  <= '0;
            mode_p2 <= 3'b000;
        end else if (take_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                res_p2  <= gate_p1;
                mode_p2 <= mode_p1;
            end
        end
    end

    assign out_valid = vld_p2;
    assign out_data  = res_p2;
    assign out_mode  = mode_p2;

`ifdef GATE_EVENT_CNT_EN
    localparam int POP_W = $clog2(CHANNELS + 1);
    localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

    function automatic logic [POP_W-1:0] popcount(input logic [CHANNELS-1:0] bits);
        logic [POP_W-1:0] n;
        n = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            n = n + POP_W'(bits[c]);
        end
        return n;
    endfunction

    // Sum is formed one bit wider than either operand so overflow is visible before clamping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc, input logic [POP_W-1:0] inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(acc) + SUM_W'(inc);
        if (sum > SUM_W'({CNT_W{1'b1}})) begin
            return {CNT_W{1'b1}};
        end
        return sum[CNT_W-1:0];
    endfunction

    logic [CNT_W-1:0] evt_p3;

    // ---- counter stage: accumulates ones of each consumed result ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_p3 <= '0;
        end else if (vld_p2 && out_ready) begin
            evt_p3 <= sat_add(evt_p3, popcount(res_p2));
        end
    end

    assign evt_count = evt_p3;
`endif

endmodule

// File: tb/tb_multi_input_logic_gate_unit.sv
// Self-checking bench: queue-based reference model of the gate pipeline plus directed literal vectors.
module tb_multi_input_logic_gate_unit;

    localparam int N  = 3;
    localparam int C  = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_mode;
    logic [N*C-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [C-1:0]  out_data;
    logic [2:0]    out_mode;

    logic          b_in_valid;
    logic          b_in_ready;
    logic [2:0]    b_in_mode;
    logic [4:0]    b_in_data;
    logic          b_out_valid;
    logic [0:0]    b_out_data;
    logic [2:0]    b_out_mode;
`ifdef GATE_EVENT_CNT_EN
    logic [CW-1:0] evt_count;
    logic [CW-1:0] b_evt_count;
`endif

    always #5 clk = ~clk;

    multi_input_logic_gate_unit #(.N_INPUTS(N), .CHANNELS(C), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
`ifdef GATE_EVENT_CNT_EN
        , .evt_count(evt_count)
`endif
    );

    multi_input_logic_gate_unit #(.N_INPUTS(5), .CHANNELS(1), .CNT_W(CW)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(1'b1), .out_data(b_out_data), .out_mode(b_out_mode)
`ifdef GATE_EVENT_CNT_EN
        , .evt_count(b_evt_count)
`endif
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference gate: defined by counting ones, not by reduction operators.
    function automatic logic [C-1:0] model(input logic [N*C-1:0] d, input logic [2:0] m);
        logic [C-1:0] r;
        for (int c = 0; c < C; c++) begin
            logic [N-1:0] bits;
            int ones;
            bits = d[c*N +: N];
            ones = $countones(bits);
            case (m)
                3'd0: r[c] = (ones == N);
                3'd1: r[c] = (ones != N);
                3'd2: r[c] = (ones > 0);
                3'd3: r[c] = (ones == 0);
                3'd4: r[c] = (ones % 2 == 1);
                3'd5: r[c] = (ones % 2 == 0);
                3'd6: r[c] = bits[0];
                default: r[c] = !bits[0];
            endcase
        end
        return r;
    endfunction

    typedef struct {
        logic [C-1:0] res;
        logic [2:0]   mode;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   consumed = 0;
    int   evt_m = 0;

    // Compare process: every cycle, before the next edge commits anything.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            evt_m = 0;
        end else begin
            check("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || out_ready));
            check("out_valid", 32'(out_valid),
                  32'((exp_q.size() > 0) && (cyc >= exp_q[0].cyc + 2)));
`ifdef GATE_EVENT_CNT_EN
            check("evt_count", 32'(evt_count), 32'(evt_m));
`endif
            if (out_valid && exp_q.size() > 0) begin
                check("out_data", 32'(out_data), 32'(exp_q[0].res));
                check("out_mode", 32'(out_mode), 32'(exp_q[0].mode));
                if (out_ready) begin
                    evt_m = evt_m + $countones(exp_q[0].res);
                    if (evt_m > (1 << CW) - 1) evt_m = (1 << CW) - 1;
                    void'(exp_q.pop_front());
                    consumed++;
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e.res  = model(in_data, in_mode);
                e.mode = in_mode;
                e.cyc  = cyc;
                exp_q.push_back(e);
            end
        end
        cyc++;
    end

    task automatic send_and_expect(input string name, input logic [2:0] m,
                                   input logic [N*C-1:0] d, input logic [C-1:0] exp);
        int  lat;
        bit  seen;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mode   = m;
        in_data   = d;
        lat  = 0;
        seen = 0;
        while (!seen && lat < 8) begin
            @(posedge clk); lat++;
            #1 in_valid = 1'b0;
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check({name, "_latency"}, 32'(lat), 32'd2);
        check({name, "_data"}, 32'(out_data), 32'(exp));
        check({name, "_mode"}, 32'(out_mode), 32'(m));
    endtask

    task automatic b_send(input string name, input logic [4:0] d, input logic exp);
        int w;
        @(posedge clk); #1;
        b_in_valid = 1'b1;
        b_in_data  = d;
        @(posedge clk); #1 b_in_valid = 1'b0;
        w = 0;
        @(negedge clk);
        while (!b_out_valid && w < 8) begin
            @(negedge clk); w++;
        end
        check({name, "_valid"}, 32'(b_out_valid), 32'd1);
        check(name, 32'(b_out_data), 32'(exp));
    endtask

    task automatic pulse_reset();
        @(posedge clk); #3 rst_n = 1'b0;
        @(posedge clk); #3 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, k, stall_acc, low_cnt, c0;
        logic [N*C-1:0] items [10];
        rst_n = 1'b0;
        in_valid = 1'b0; in_mode = 3'b000; in_data = '0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_mode = 3'b100; b_in_data = '0;

        // Reset state
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_mode", 32'(out_mode), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Test 1 and hand-computed pins of the gate table
        send_and_expect("nand_fff", 3'b001, 12'hFFF, 4'h0);
        send_and_expect("nand_000", 3'b001, 12'h000, 4'hF);
        send_and_expect("xor_ch0",  3'b100, 12'h007, 4'b0001);
        send_and_expect("xnor_ch0", 3'b101, 12'h005, 4'hF);
        send_and_expect("buf_ch0",  3'b110, 12'h002, 4'h0);
        send_and_expect("not_ch0",  3'b111, 12'h002, 4'hF);
        send_and_expect("or_ch3",   3'b010, 12'h400, 4'b1000);
        send_and_expect("nor_ch3",  3'b011, 12'h400, 4'b0111);
        send_and_expect("and_ch2",  3'b000, 12'h1C0, 4'b0100);

        // Test 2: all modes x all ch0 patterns, back to back
        for (int m = 0; m < 8; m++) begin
            for (int p = 0; p < 8; p++) begin
                @(posedge clk); #1;
                in_valid = 1'b1; in_mode = 3'(m); in_data = 12'(p);
            end
        end
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);

        // Test 3: 10-item stream with a four-cycle stall starting on an empty pipeline
        for (int i = 0; i < 10; i++) items[i] = 12'(i * 12'h2A7 + 12'h0B1);
        c0 = consumed; idx = 0; k = 0; stall_acc = 0; low_cnt = 0;
        while (idx < 10 && k < 60) begin
            @(posedge clk); #1;
            out_ready = !(k <= 3);
            in_valid  = 1'b1;
            in_mode   = 3'(idx % 8);
            in_data   = items[idx];
            @(negedge clk);
            if (in_ready) begin
                if (k <= 3) stall_acc++;
                idx++;
            end else if (k <= 3) low_cnt++;
            k++;
        end
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("stream_sent", 32'(idx), 32'd10);
        check("stall_accepts", 32'(stall_acc), 32'd2);
        check("stall_ready_low", 32'(low_cnt), 32'd2);
        check("stream_consumed", 32'(consumed - c0), 32'd10);

        // Test 4: asynchronous reset with both stages full
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 3'b001; in_data = 12'h000;
        repeat (2) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_out_data", 32'(out_data), 32'hF);
        check("full_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_out_data", 32'(out_data), 32'd0);
        check("async_rst_out_mode", 32'(out_mode), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_out_valid", 32'(out_valid), 32'd0);
        send_and_expect("after_rst", 3'b010, 12'h001, 4'b0001);

`ifdef GATE_EVENT_CNT_EN
        // Test 5: saturating event counter
        pulse_reset();
        @(negedge clk);
        check("evt_after_rst", 32'(evt_count), 32'd0);
        begin
            int exp_evt [5] = '{4, 8, 12, 15, 15};
            for (int i = 0; i < 5; i++) begin
                send_and_expect("evt_and", 3'b000, 12'hFFF, 4'hF);
                @(negedge clk);
                check("evt_count_step", 32'(evt_count), 32'(exp_evt[i]));
            end
        end
`endif

        // Test 6: five-input single-channel instance, parity
        b_send("b_xor_10110", 5'b10110, 1'b1);
        b_send("b_xor_10010", 5'b10010, 1'b0);
        b_send("b_xor_11111", 5'b11111, 1'b1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
